tone_meter: RTL and testbench
=============================

TONE_METER -- requirements
Module: tone_meter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter GATE_CYCLES, default 5_000_000, measurement window length in clocks (100 ms).
REQ-003 Parameter TOL_HZ, default 20, inclusive match tolerance in Hz.
REQ-004 Port FPGA_CLK1_50  input  1  sole clock; all state on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port toneIn  input  1  asynchronous square wave to be measured (speaker loopback or comparator).
REQ-007 Port measuredFrequency  output  32  frequency of the last completed window in Hz.
REQ-008 Port freqValid  output  1  one-clock pulse when measuredFrequency/toneMatch update.
REQ-009 Port toneDetected  output  1  level; high when the last completed window counted at least one edge.
REQ-010 Port toneMatch  output  4  one-hot Simon tone match for the last window; 0000 when none.

Function
REQ-011 toneIn SHALL pass a 2-flop synchronizer; rising edge = synchronized high AND previous synchronized low.
REQ-012 Gate counter SHALL count 0..GATE_CYCLES-1 and wrap to 0; the cycle at GATE_CYCLES-1 is the terminal cycle.
REQ-013 Edge counter SHALL increment by 1 per detected rising edge; width = ceil(log2(GATE_CYCLES/2+1)); it cannot overflow.
REQ-014 An edge on the terminal cycle SHALL be counted in the closing window; the next window SHALL start at count 0.
REQ-015 On the clock after the terminal cycle, measuredFrequency SHALL load edgeCount * (CLK_HZ/GATE_CYCLES) (default scale 10), and freqValid SHALL pulse for one clock.
REQ-016 toneDetected and toneMatch SHALL update on the same edge as measuredFrequency, from the same count.
REQ-017 toneMatch[i] SHALL be 1 iff |f - TONE_HZ[i]| <= TOL_HZ, where f is the new measuredFrequency; subtraction SHALL be unsigned-safe (larger minus smaller).
REQ-018 Tone table: index 0 = 415 Hz (green), 1 = 310 Hz (red), 2 = 252 Hz (yellow), 3 = 209 Hz (blue).
REQ-019 At most one toneMatch bit SHALL be set; TOL_HZ SHALL be below half the minimum table spacing (elaboration-time assertion).
REQ-020 Outputs SHALL hold their values between freqValid pulses.
REQ-021 The first window after reset release SHALL be discarded: no freqValid and no output update, so that partial windows and synchronizer start-up edges are never reported.
REQ-022 toneIn constant at 0 or 1 for a full window SHALL report 0 Hz, toneDetected 0, toneMatch 0000.

Reset
REQ-023 While reset is high: synchronizer flops, edge-detect flop, gate counter, edge counter and discard flag SHALL be 0; measuredFrequency 0; freqValid 0; toneDetected 0; toneMatch 0000.
REQ-024 Reset asserted mid-window SHALL clear outputs immediately (asynchronously) and abandon the partial count.
REQ-025 After release, the first freqValid SHALL occur on the clock after the second terminal cycle (2*GATE_CYCLES+1 clocks after release).

Structure
REQ-026 Shared package simon_pkg SHALL hold the tone table constant TONE_HZ[0:3], the tone-index enum (GREEN, RED, YELLOW, BLUE) and CLK_HZ_DEFAULT, shared with the tone generator.
REQ-027 One sub-module, edge_sync (2-flop synchronizer plus rising-edge pulse), SHALL be instantiated; all other logic stays in tone_meter.

Verification (default parameters)
REQ-028 415 Hz toneIn (period 120_482 clocks) -> each freqValid reports 410 or 420, toneMatch 0001, toneDetected 1.
REQ-029 209 Hz and 310 Hz in sequence -> 200/210 with toneMatch 1000, then 310 with toneMatch 0010.
REQ-030 toneIn held 0, then 1 kHz -> 0 Hz with toneMatch 0000 and toneDetected 0, then 1000 Hz with toneMatch 0000 and toneDetected 1.
REQ-031 Reset pulsed at gate count 2_000_000 of a 252 Hz tone -> outputs 0 the same cycle; the next freqValid comes exactly 2*GATE_CYCLES+1 clocks after release and reports 250 or 260 with toneMatch 0100.
REQ-032 Forced synchronized edge on the terminal cycle -> counted in the closing window (reported count +1); the next window starts at 0.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared Simon-game constants: tone table, tone index names and the board clock.
// Used by both the tone generator and the tone meter so they agree on pitches.
package simon_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } tone_e;

  localparam int          NUM_TONES      = 4;
  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;
  localparam int unsigned TONE_HZ [0:NUM_TONES-1] = '{415, 310, 252, 209};

  // Smallest distance between any two table pitches; bounds how wide a match tolerance may be.
  function automatic int unsigned min_tone_spacing();
    int unsigned best;
    int unsigned d;
    best = 32'hFFFF_FFFF;
    for (int i = 0; i < NUM_TONES; i++) begin
      for (int j = i + 1; j < NUM_TONES; j++) begin
        d = (TONE_HZ[i] > TONE_HZ[j]) ? TONE_HZ[i] - TONE_HZ[j] : TONE_HZ[j] - TONE_HZ[i];
        if (d < best) best = d;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input, followed by a one-clock
// rising-edge pulse taken from the synchronized level.
module edge_sync (
  input  logic FPGA_CLK1_50,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/tone_meter.sv
// Gated frequency counter: counts rising edges of toneIn over a fixed window,
// reports the frequency in Hz and which Simon tone (if any) it matches.
module tone_meter
  import simon_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int unsigned GATE_CYCLES = 5_000_000,
  parameter int unsigned TOL_HZ      = 20
) (
  input  logic        FPGA_CLK1_50,
  input  logic        reset,
  input  logic        toneIn,
  output logic [31:0] measuredFrequency,
  output logic        freqValid,
  output logic        toneDetected,
  output logic [3:0]  toneMatch
);

  localparam int unsigned GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned EDGE_W      = $clog2(GATE_CYCLES / 2 + 1);
  localparam logic [31:0] SCALE       = 32'(CLK_HZ / GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam int unsigned MIN_SPACING = min_tone_spacing();

  // A tolerance this wide could light two match bits for one frequency.
  if (2 * TOL_HZ >= MIN_SPACING) begin : g_tol_too_wide
    $error("tone_meter: TOL_HZ must be below half the minimum tone spacing");
  end

  logic                  rise;
  logic                  terminal;
  logic [GATE_W-1:0]     gate_count;
  logic [EDGE_W-1:0]     edge_count;
  logic [EDGE_W-1:0]     closing_count;
  logic                  window_done;
  logic                  first_window_seen;
  logic [31:0]           new_freq;
  logic [31:0]           diff;
  logic [NUM_TONES-1:0]  new_match;

  edge_sync u_edge_sync (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .reset        (reset),
    .async_in     (toneIn),
    .rise         (rise)
  );

  assign terminal = (gate_count == GATE_LAST);

  // The closing count includes an edge landing on the terminal cycle; the very
  // first window after reset only arms first_window_seen and is never reported.
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      gate_count        <= '0;
      edge_count        <= '0;
      closing_count     <= '0;
      window_done       <= 1'b0;
      first_window_seen <= 1'b0;
    end else if (terminal) begin
      gate_count        <= '0;
      edge_count        <= '0;
      closing_count     <= edge_count + EDGE_W'(rise);
      window_done       <= first_window_seen;
      first_window_seen <= 1'b1;
    end else begin
      gate_count        <= gate_count + 1'b1;
      edge_count        <= edge_count + EDGE_W'(rise);
      window_done       <= 1'b0;
    end
  end

  always_comb begin
    new_freq  = 32'(closing_count) * SCALE;
    new_match = '0;
    diff      = '0;
    for (int i = 0; i < NUM_TONES; i++) begin
      diff = (new_freq >= TONE_HZ[i]) ? new_freq - TONE_HZ[i] : TONE_HZ[i] - new_freq;
      new_match[i] = (diff <= TOL_HZ);
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      measuredFrequency <= '0;
      freqValid         <= 1'b0;
      toneDetected      <= 1'b0;
      toneMatch         <= '0;
    end else begin
      freqValid <= window_done;
      if (window_done) begin
        measuredFrequency <= new_freq;
        toneDetected      <= (closing_count != '0);
        toneMatch         <= new_match;
      end
    end
  end

endmodule

// File: tb/tb_tone_meter.sv
// Self-checking bench for tone_meter with a shortened gate (same 10 Hz resolution):
// table-driven tones, random tones, terminal-cycle edge and mid-window reset.
module tb_tone_meter;
  import simon_pkg::*;

  localparam int CLK_HZ = 10_000;
  localparam int G      = 1000;
  localparam int TOL    = 20;
  localparam int SCALE  = CLK_HZ / G;
  localparam int NW     = 128;

  logic        FPGA_CLK1_50 = 1'b0;
  logic        reset = 1'b1;
  logic        toneIn = 1'b0;
  logic [31:0] measuredFrequency;
  logic        freqValid;
  logic        toneDetected;
  logic [3:0]  toneMatch;

  tone_meter #(.CLK_HZ(CLK_HZ), .GATE_CYCLES(G), .TOL_HZ(TOL)) dut (
    .FPGA_CLK1_50      (FPGA_CLK1_50),
    .reset             (reset),
    .toneIn            (toneIn),
    .measuredFrequency (measuredFrequency),
    .freqValid         (freqValid),
    .toneDetected      (toneDetected),
    .toneMatch         (toneMatch)
  );

  always #5 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  typedef struct {
    int       freq_hz;
    bit       hold_high;
    int       windows;
    int       exp_lo;
    int       exp_hi;
    bit [3:0] exp_match;
    bit       exp_det;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int fails  = 0;
  int cyc;
  int phase = 0;
  int cur_freq = 0;
  bit cur_high = 0;
  int cur_entry = -1;
  bit entry_start = 0;
  int pulse_at = -1;
  bit prev_drv;
  int first_valid;
  int win_cnt   [NW];
  int win_entry [NW];
  int rep_freq  [NW];
  int       exp_freq;
  bit [3:0] exp_match;
  bit       exp_det;

  function automatic bit [3:0] ref_match(input int f);
    bit [3:0] m;
    int d;
    m = '0;
    for (int i = 0; i < NUM_TONES; i++) begin
      d = f - int'(TONE_HZ[i]);
      if (d < 0) d = -d;
      m[i] = (d <= TOL);
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_range(input string name, input longint actual, input longint lo, input longint hi);
    checks++;
    if (actual != lo && actual != hi) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d or %0d (cycle %0d)", name, actual, lo, hi, cyc);
    end
  endtask

  task automatic model_clear();
    cyc = 0;
    prev_drv = 1'b0;
    first_valid = -1;
    exp_freq = 0;
    exp_match = '0;
    exp_det = 1'b0;
    for (int i = 0; i < NW; i++) begin
      win_cnt[i]   = 0;
      win_entry[i] = -1;
      rep_freq[i]  = -1;
    end
  endtask

  // Drive toneIn for the current cycle and credit any new rising edge to the
  // window it reaches after the two synchronizer stages.
  task automatic applyStimulus();
    bit v;
    if (cur_high)          v = 1'b1;
    else if (cur_freq == 0) v = 1'b0;
    else                   v = (phase >= CLK_HZ / 2);
    if (pulse_at >= 0 && cyc >= pulse_at && cyc < pulse_at + 5) v = 1'b1;
    toneIn = v;
    if (v && !prev_drv && (cyc + 2) / G < NW) win_cnt[(cyc + 2) / G]++;
    prev_drv = v;
    if (cyc % G == 0 && cyc / G < NW) win_entry[cyc / G] = entry_start ? -1 : cur_entry;
    entry_start = 1'b0;
    phase = phase + cur_freq;
    if (phase >= CLK_HZ) phase = phase - CLK_HZ;
  endtask

  task automatic monitor_cycle();
    bit exp_valid;
    int w;
    exp_valid = (cyc >= 2 * G + 1) && ((cyc - 1) % G == 0);
    if (exp_valid) begin
      w = (cyc - 1) / G - 1;
      exp_freq  = win_cnt[w] * SCALE;
      exp_det   = (win_cnt[w] != 0);
      exp_match = ref_match(exp_freq);
      if (first_valid < 0) first_valid = cyc;
      rep_freq[w] = int'(measuredFrequency);
      if (win_entry[w] >= 0) begin
        check_range("tbl_freq", measuredFrequency, vecs[win_entry[w]].exp_lo, vecs[win_entry[w]].exp_hi);
        checkOutput("tbl_match", toneMatch, vecs[win_entry[w]].exp_match);
        checkOutput("tbl_detected", toneDetected, vecs[win_entry[w]].exp_det);
      end
    end
    checkOutput("freqValid", freqValid, exp_valid);
    checkOutput("measuredFrequency", measuredFrequency, exp_freq);
    checkOutput("toneMatch", toneMatch, exp_match);
    checkOutput("toneDetected", toneDetected, exp_det);
  endtask

  task automatic tick();
    applyStimulus();
    @(posedge FPGA_CLK1_50);
    cyc++;
    #1;
    monitor_cycle();
    @(negedge FPGA_CLK1_50);
  endtask

  task automatic run_entry(input int freq, input bit high, input int windows, input int entry);
    cur_freq    = freq;
    cur_high    = high;
    cur_entry   = entry;
    entry_start = 1'b1;
    repeat (windows * G) tick();
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_freq"}, measuredFrequency, 0);
    checkOutput({tag, "_valid"}, freqValid, 0);
    checkOutput({tag, "_detected"}, toneDetected, 0);
    checkOutput({tag, "_match"}, toneMatch, 0);
  endtask

  initial begin
    int k;
    int f;
    vecs[0] = '{415,  1'b0, 4, 410,  420,  4'b0001, 1'b1};
    vecs[1] = '{209,  1'b0, 3, 200,  210,  4'b1000, 1'b1};
    vecs[2] = '{310,  1'b0, 3, 310,  310,  4'b0010, 1'b1};
    vecs[3] = '{0,    1'b0, 3, 0,    0,    4'b0000, 1'b0};
    vecs[4] = '{1000, 1'b0, 3, 1000, 1000, 4'b0000, 1'b1};
    vecs[5] = '{0,    1'b1, 3, 0,    0,    4'b0000, 1'b0};
    vecs[6] = '{252,  1'b0, 3, 250,  260,  4'b0100, 1'b1};

    model_clear();
    repeat (3) @(posedge FPGA_CLK1_50);
    #1;
    check_all_zero("reset");
    @(negedge FPGA_CLK1_50);
    reset = 1'b0;
    model_clear();

    for (int e = 0; e < 7; e++)
      run_entry(vecs[e].freq_hz, vecs[e].hold_high, vecs[e].windows, e);

    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 1) f = int'(TONE_HZ[$urandom_range(0, 3)]) + int'($urandom_range(0, 50)) - 25;
      else            f = int'($urandom_range(0, 1500));
      run_entry(f, 1'b0, 2, -1);
    end

    // Single edge timed to reach the edge detector on the terminal cycle of window k+1.
    k = cyc / G;
    pulse_at = (k + 2) * G - 3;
    run_entry(0, 1'b0, 3, -1);
    run_entry(0, 1'b0, 1, -1);
    pulse_at = -1;
    checkOutput("terminal_edge_window", rep_freq[k + 1], SCALE);
    checkOutput("terminal_next_window", rep_freq[k + 2], 0);

    // Reset asserted at gate count 400 of a 252 Hz tone.
    run_entry(252, 1'b0, 2, 6);
    while (cyc % G != 400) tick();
    applyStimulus();
    checkOutput("pre_reset_freq_nonzero", (measuredFrequency != 0), 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (3) begin
      @(posedge FPGA_CLK1_50);
      #1;
      check_all_zero("held_reset");
    end
    @(negedge FPGA_CLK1_50);
    reset = 1'b0;
    model_clear();
    run_entry(252, 1'b0, 4, 6);
    checkOutput("first_valid_latency", first_valid, 2 * G + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
